// File: rtl/weight_update_if.sv
// weight_update_if: groups the control handshake, operand inputs and live
// weight outputs of the weight_update stage into one bundle.
// master = the upstream driver (optimizer / testbench), slave = weight_update.
interface weight_update_if #(
   parameter int W     = 10,
   parameter int N_IN  = 4,
   parameter int N_HID = 5,
   parameter int N_OUT = 3
);

   logic                start;
   logic                load;
   logic                load_sel;
   logic [4:0]          load_addr;
   logic signed [W-1:0] load_data;

   logic signed [W-1:0] in_act   [N_IN];
   logic signed [W-1:0] out0_cal [N_HID];
   logic signed [W-1:0] delta0   [N_HID];
   logic signed [W-1:0] delta1   [N_OUT];

   logic signed [W-1:0] w0 [N_IN*N_HID];
   logic signed [W-1:0] w1 [N_HID*N_OUT];
   logic                busy;
   logic                done;

   modport master (
      output start, load, load_sel, load_addr, load_data,
      output in_act, out0_cal, delta0, delta1,
      input  w0, w1, busy, done
   );

   modport slave (
      input  start, load, load_sel, load_addr, load_data,
      input  in_act, out0_cal, delta0, delta1,
      output w0, w1, busy, done
   );

endinterface

// File: rtl/weight_update.sv
// weight_update: one gradient-descent step over both weight banks using a
// single shared multiplier, one weight per cycle (layer 1 first, then layer 0).
// Holds the live weight registers read by the forward-pass datapath.
// Optional feature: define WEIGHT_SAT_EN to clamp updated weights to the
// signed W-bit range; otherwise updated weights wrap to their low W bits.
module weight_update #(
   parameter int W        = 10,
   parameter int FRAC     = 6,
   parameter int N_IN     = 4,
   parameter int N_HID    = 5,
   parameter int N_OUT    = 3,
   parameter int LR_SHIFT = 3
) (
   input logic           clk_i,
   input logic           rst_ni,
   weight_update_if.slave bus
);

   localparam int N_W0  = N_IN * N_HID;
   localparam int N_W1  = N_HID * N_OUT;
   localparam int SHIFT = FRAC + LR_SHIFT;

   localparam logic [4:0] LAST_W1 = 5'(N_W1 - 1);
   localparam logic [4:0] LAST_W0 = 5'(N_W0 - 1);
   localparam logic [4:0] LAST_K  = 5'(N_OUT - 1);
   localparam logic [4:0] LAST_J  = 5'(N_HID - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UPD1 = 2'd1,
      UPD0 = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [4:0] row_q, row_d;
   logic [4:0] col_q, col_d;
   logic       latchEn;
   logic       loadEn;

   logic signed [W-1:0] inAct_q   [N_IN];
   logic signed [W-1:0] out0Cal_q [N_HID];
   logic signed [W-1:0] delta0_q  [N_HID];
   logic signed [W-1:0] delta1_q  [N_OUT];

   logic signed [W-1:0] w0_q [N_W0];
   logic signed [W-1:0] w1_q [N_W1];

   logic signed [W-1:0]   mulDelta;
   logic signed [W-1:0]   mulAct;
   logic signed [W-1:0]   wCur;
   logic signed [W-1:0]   wNew;
   logic signed [2*W-1:0] product;
   logic signed [W:0]     step;
   logic signed [W:0]     wWide;

   // State, flat weight index and its row/column decomposition registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Next-state logic; row/col track idx so no divider is needed.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      row_d   = row_q;
      col_d   = col_q;
      latchEn = 1'b0;
      loadEn  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               loadEn = 1'b1;
            end else if (bus.start) begin
               latchEn = 1'b1;
               state_d = UPD1;
               idx_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         UPD1: begin
            idx_d = idx_q + 5'd1;
            if (col_q == LAST_K) begin
               col_d = '0;
               row_d = row_q + 5'd1;
            end else begin
               col_d = col_q + 5'd1;
            end
            if (idx_q == LAST_W1) begin
               state_d = UPD0;
               idx_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         UPD0: begin
            idx_d = idx_q + 5'd1;
            if (col_q == LAST_J) begin
               col_d = '0;
               row_d = row_q + 5'd1;
            end else begin
               col_d = col_q + 5'd1;
            end
            if (idx_q == LAST_W0) begin
               state_d = DONE;
               idx_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Snapshot of all operands at the accepted Start edge; later input changes are ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_IN; i++) inAct_q[i] <= '0;
         for (int j = 0; j < N_HID; j++) begin
            out0Cal_q[j] <= '0;
            delta0_q[j]  <= '0;
         end
         for (int k = 0; k < N_OUT; k++) delta1_q[k] <= '0;
      end else if (latchEn) begin
         inAct_q   <= bus.in_act;
         out0Cal_q <= bus.out0_cal;
         delta0_q  <= bus.delta0;
         delta1_q  <= bus.delta1;
      end
   end

   // Operand select for the shared multiplier: layer 1 uses (delta1[k], out0_cal[j]), layer 0 uses (delta0[j], in_act[i]).
   always_comb begin
      mulDelta = '0;
      mulAct   = '0;
      wCur     = '0;
      if (state_q == UPD1) begin
         for (int k = 0; k < N_OUT; k++)
            if (col_q == 5'(k)) mulDelta = delta1_q[k];
         for (int j = 0; j < N_HID; j++)
            if (row_q == 5'(j)) mulAct = out0Cal_q[j];
         for (int n = 0; n < N_W1; n++)
            if (idx_q == 5'(n)) wCur = w1_q[n];
      end else if (state_q == UPD0) begin
         for (int j = 0; j < N_HID; j++)
            if (col_q == 5'(j)) mulDelta = delta0_q[j];
         for (int i = 0; i < N_IN; i++)
            if (row_q == 5'(i)) mulAct = inAct_q[i];
         for (int n = 0; n < N_W0; n++)
            if (idx_q == 5'(n)) wCur = w0_q[n];
      end
   end

   // Update arithmetic: full-width product, floor shift by learning rate, subtract at W+1 bits, then clamp or wrap.
   always_comb begin
      product = (2*W)'(mulDelta) * (2*W)'(mulAct);
      step    = (W+1)'(product >>> SHIFT);
      wWide   = (W+1)'(wCur) - step;
`ifdef WEIGHT_SAT_EN
      if (wWide[W] != wWide[W-1]) begin
         wNew = wWide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         wNew = W'(wWide);
      end
`else
      wNew = W'(wWide);
`endif
   end

   // Weight banks: host loads in IDLE, one weight rewritten per cycle during the pass.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int n = 0; n < N_W0; n++) w0_q[n] <= '0;
         for (int n = 0; n < N_W1; n++) w1_q[n] <= '0;
      end else if (loadEn) begin
         if (!bus.load_sel) begin
            for (int n = 0; n < N_W0; n++)
               if (bus.load_addr == 5'(n)) w0_q[n] <= bus.load_data;
         end else begin
            for (int n = 0; n < N_W1; n++)
               if (bus.load_addr == 5'(n)) w1_q[n] <= bus.load_data;
         end
      end else if (state_q == UPD1) begin
         for (int n = 0; n < N_W1; n++)
            if (idx_q == 5'(n)) w1_q[n] <= wNew;
      end else if (state_q == UPD0) begin
         for (int n = 0; n < N_W0; n++)
            if (idx_q == 5'(n)) w0_q[n] <= wNew;
      end
   end

   assign bus.w0   = w0_q;
   assign bus.w1   = w1_q;
   assign bus.busy = (state_q == UPD1) || (state_q == UPD0);
   assign bus.done = (state_q == DONE);

endmodule

// File: doc/weight_update.md
# weight_update

Weight-update stage of the on-chip training path. It sits directly downstream of `WeightOptimization`, which produces the error terms `delta1[0:2]` (output layer) and `delta0[0:4]` (hidden layer). On a `Start` pulse it latches the deltas and activations, then applies one gradient-descent step to every weight with a single shared multiplier, one weight per cycle. It holds the live weight registers read by the forward-pass datapath.

## Interface
- `W`, 10: data and weight width, signed two's complement
- `FRAC`, 6: fractional bits of all operands
- `N_IN`, 4: network inputs
- `N_HID`, 5: hidden neurons
- `N_OUT`, 3: output neurons
- `LR_SHIFT`, 3: learning rate = 2^-LR_SHIFT
- `Clock` in 1: sole clock, rising edge
- `Rst` in 1: reset, asynchronous, active-low
- `Start` in 1: begin an update pass (sampled in IDLE only)
- `Load` in 1: write one weight from `load_data` (IDLE only)
- `load_sel` in 1: 0 = layer-0 bank, 1 = layer-1 bank
- `load_addr` in 5: flat weight index within the bank
- `load_data` in W: weight value
- `in_act[0:N_IN-1]` in W each: network inputs of the sample
- `out0_cal[0:N_HID-1]` in W each: hidden activations
- `delta0[0:N_HID-1]` in W each: hidden-layer error terms
- `delta1[0:N_OUT-1]` in W each: output-layer error terms
- `w0[0:N_IN*N_HID-1]` out W each: layer-0 weights, index i*N_HID+j (input i -> hidden j)
- `w1[0:N_HID*N_OUT-1]` out W each: layer-1 weights, index j*N_OUT+k (hidden j -> output k)
- `Busy` out 1: high in UPD1/UPD0
- `Done` out 1: one-cycle pulse at pass completion

## Operation
- FSM: IDLE -> UPD1 -> UPD0 -> DONE -> IDLE.
- IDLE: `Load`=1 writes `load_data` to the selected weight; `load_addr` beyond bank size is ignored. Otherwise `Start`=1 latches all `in_act`, `out0_cal`, `delta0`, `delta1` into internal registers, clears index, enters UPD1. `Load` and `Start` together: Load wins, Start dropped.
- UPD1: each cycle updates `w1[idx]` using `delta1[k]`, `out0_cal[j]` (j = idx / N_OUT, k = idx mod N_OUT); after idx = N_HID*N_OUT-1 enters UPD0 with idx = 0.
- UPD0: each cycle updates `w0[idx]` using `delta0[j]`, `in_act[i]` (i = idx / N_HID, j = idx mod N_HID); after last index enters DONE.
- DONE: `Done`=1 for one cycle, then IDLE.
- Update arithmetic: p = delta * act, full 2W-bit signed product; s = p >>> (FRAC + LR_SHIFT), arithmetic shift, floor rounding; w_new = w - s computed at W+1 bits, then reduced to W bits per Configuration.
- `Start`, `Load` outside IDLE are ignored. Input changes after the Start edge do not affect the pass.
- Layer-1 uses pre-update values only; layer-0 update does not read layer-1 weights.

## Timing
- Reset (`Rst`=0, any time, including mid-pass): all `w0`, `w1` = 0, state IDLE, `Busy`=0, `Done`=0, latched operands = 0. The pass in progress is abandoned.
- Start sampled at edge t. `w1[n]` is updated at edge t+1+n. `w0[m]` is updated at edge t+1+N_HID*N_OUT+m. Defaults: w1 at t+1..t+15, w0 at t+16..t+35.
- `Busy` high from after edge t through edge t+35. `Done` high between edges t+35 and t+36. IDLE again after t+36, so the next `Start` is accepted at t+36 at earliest.
- `Load` writes take effect at the sampling edge. Weights read back on the next cycle.

## Configuration
- `WEIGHT_SAT_EN` defined: w_new clamps to [-2^(W-1), 2^(W-1)-1] (default -512..511).
- Not defined: w_new is truncated to its low W bits (two's-complement wrap).

## Test plan
- Reset mid-pass: Start, then drop `Rst` at t+10 -> all weights 0, `Busy`=0, `Done` never pulses.
- Basic step: `Load` w1[0]=0; delta1[0]=64, out0_cal[0]=64, others 0; Start -> w1[0]=-8 (10'h3F8), all other weights unchanged. `Done` pulses exactly 36 cycles after Start.
- Sign and floor: w0[0]=0, delta0[0]=-1, in_act[0]=1 -> s=-1, w0[0]=+1. w0[5]=0, delta0[0]=-64, in_act[1]=64 -> w0[5]=+8.
- Saturation: w1[14]=-510, delta1[2]=511, out0_cal[4]=511 -> s=510. With `WEIGHT_SAT_EN`, w1[14]=-512 (10'h200). Without it, w1[14]=4.
- Handshake: Start held high through the pass plus `Load` at t+5 -> Load ignored, one pass only. `Load` and `Start` both high in IDLE -> weight written, no pass, `Busy` stays 0.
- Operand latching: change all deltas to 0 at t+1 -> updates still use the values latched at t.
